// File: rtl/data_memory_sync.sv
// Dual-read, single-write data memory for the uProcessor datapath.
// After reset a hardware sequencer preloads every word before Ready rises.
// Out-of-range accesses are flagged one cycle later on AddrErr.
//
// state | meaning
// ------+---------------------------------------------------------
// INIT  | preload mem[cnt] with the init pattern, user inputs ignored
// RUN   | Ready high, user writes and both read ports active
module data_memory_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_LEN   = 256,
    parameter int INIT_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] WrAddr,
    input  logic [DATA_WIDTH-1:0] Accu,
    input  logic                  ReadEnA,
    input  logic [ADDR_WIDTH-1:0] RdAddrA,
    input  logic                  ReadEnB,
    input  logic [ADDR_WIDTH-1:0] RdAddrB,
    output logic [DATA_WIDTH-1:0] DataOutA,
    output logic [DATA_WIDTH-1:0] DataOutB,
    output logic                  ValidA,
    output logic                  ValidB,
    output logic                  Ready,
    output logic                  AddrErr
);

    typedef enum logic {INIT, RUN} state_t;

    // Index width is just enough to address DATA_LEN words; the full
    // address is still used for the range check so nothing aliases.
    localparam int IDX_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [ADDR_WIDTH:0]   LEN_EXT = (ADDR_WIDTH+1)'(DATA_LEN);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DATA_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [DATA_LEN];

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] init_val;
    logic                  run;
    logic                  wr_ok, ra_ok, rb_ok;
    logic                  wr_hit;

    assign run    = (state == RUN);
    assign Ready  = run;
    assign wr_ok  = ({1'b0, WrAddr}  < LEN_EXT);
    assign ra_ok  = ({1'b0, RdAddrA} < LEN_EXT);
    assign rb_ok  = ({1'b0, RdAddrB} < LEN_EXT);
    assign wr_hit = run && WriteEnable && wr_ok;

    assign init_val = (INIT_MODE == 1) ? DATA_WIDTH'(cnt) : '0;

    // FSM and preload counter registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: step through the preload, leave INIT on the last word
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
                state_nxt = RUN;
            end
        end
    end

    // Single write port shared by the preload sequencer and user writes;
    // no reset term so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt[IDX_W-1:0]] <= init_val;
        end else if (wr_hit) begin
            mem[WrAddr[IDX_W-1:0]] <= Accu;
        end
    end

    // Registered read ports with write-first bypass, plus the error flag
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            DataOutA <= '0;
            DataOutB <= '0;
            ValidA   <= 1'b0;
            ValidB   <= 1'b0;
            AddrErr  <= 1'b0;
        end else if (run) begin
            ValidA  <= ReadEnA;
            ValidB  <= ReadEnB;
            AddrErr <= (WriteEnable && !wr_ok) ||
                       (ReadEnA && !ra_ok) ||
                       (ReadEnB && !rb_ok);
            if (ReadEnA) begin
                if (!ra_ok)
                    DataOutA <= '0;
                else if (wr_hit && (WrAddr == RdAddrA))
                    DataOutA <= Accu;
                else
                    DataOutA <= mem[RdAddrA[IDX_W-1:0]];
            end
            if (ReadEnB) begin
                if (!rb_ok)
                    DataOutB <= '0;
                else if (wr_hit && (WrAddr == RdAddrB))
                    DataOutB <= Accu;
                else
                    DataOutB <= mem[RdAddrB[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: doc/data_memory_sync.md
Name: data_memory_sync

Overview:
- Next-generation data memory for the uProcessor datapath.
- Parametrised depth and width, one synchronous write port and two independent registered read ports (A and B), so the ALU can fetch two operands per cycle.
- Hardware init sequencer preloads the memory after reset. The block raises Ready only once the preload has completed.
- Out-of-range accesses are reported through a registered error flag.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address width in bits; legal addresses satisfy 0 ≤ addr < DATA_LEN.
- DATA_LEN, 256, number of words; must be in the range 2..2^ADDR_WIDTH.
- INIT_MODE, 1, preload pattern: 0 writes all zeros; 1 writes mem[i] = i truncated to DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- WriteEnable  in  1  write strobe, sampled at the rising edge.
- WrAddr  in  ADDR_WIDTH  write address.
- Accu  in  DATA_WIDTH  write data.
- ReadEnA  in  1  read request, port A.
- RdAddrA  in  ADDR_WIDTH  read address, port A.
- ReadEnB  in  1  read request, port B.
- RdAddrB  in  ADDR_WIDTH  read address, port B.
- DataOutA  out  DATA_WIDTH  registered read data, port A.
- DataOutB  out  DATA_WIDTH  registered read data, port B.
- ValidA  out  1  DataOutA updated this cycle (1-cycle pulse).
- ValidB  out  1  DataOutB updated this cycle (1-cycle pulse).
- Ready  out  1  preload done, memory accepting accesses.
- AddrErr  out  1  out-of-range access detected on the previous edge.

Behaviour:
- Reset: nReset low asynchronously forces the following. Reset does not clear the array itself; the preload restores it.
  - state = INIT, init counter = 0.
  - DataOutA = DataOutB = 0.
  - ValidA = ValidB = Ready = AddrErr = 0.
- FSM, two states: INIT and RUN.
- INIT:
  - Each rising edge writes the INIT_MODE pattern value to mem[cnt], then cnt <= cnt + 1.
  - When cnt == DATA_LEN-1, the write still occurs and state becomes RUN.
  - The preload therefore takes exactly DATA_LEN edges after nReset deasserts.
  - All user inputs are ignored. Valid, AddrErr and Ready stay 0, and DataOut holds 0.
- RUN:
  - Ready = 1 (registered). Ready asserts on the same edge that performs the final preload write.
- Write:
  - If WriteEnable = 1 and WrAddr < DATA_LEN, mem[WrAddr] <= Accu at the edge.
  - If WrAddr ≥ DATA_LEN, the write is dropped.
- Read, per port, shown for A; B is identical and independent:
  - If ReadEnA = 1 at edge N, then at N+1 DataOutA = mem[RdAddrA] and ValidA = 1. Read latency is 1 cycle.
  - If ReadEnA = 0, DataOutA holds its last value and ValidA = 0.
  - If RdAddrA ≥ DATA_LEN, DataOutA = 0 and ValidA = 1.
- Write-first bypass:
  - An enabled read in the same cycle as an in-range write to the same address returns Accu, not the old contents.
  - Applies to each port separately.
- Both read ports at the same address is legal; both return identical data.
- AddrErr:
  - Registered. AddrErr = 1 at N+1 if, at edge N, any enabled access had an address ≥ DATA_LEN. This covers the write and either read.
  - Otherwise AddrErr = 0.
  - AddrErr cannot assert when DATA_LEN = 2^ADDR_WIDTH.
- Reset mid-INIT or mid-RUN: the memory immediately returns to reset values, and the preload restarts from address 0 after release.
- The read/write path is fully synchronous; there is no combinational path from inputs to outputs.
- The array has no reset term, so it is inferable as block RAM; only the read registers, FSM, counter and flags are reset.

Test Plan:
1. Preload, defaults, INIT_MODE=1: release nReset, hold ReadEnA=1 → Ready=0 and ValidA=0 for edges 1..255; Ready=1 after edge 256. Then RdAddrA=0x05 → DataOutA=0x05, ValidA=1 one cycle later.
2. Write/read with bypass: in RUN, WriteEnable=1, WrAddr=0x10, Accu=0xA5, ReadEnA=1, RdAddrA=0x10, ReadEnB=1, RdAddrB=0x11 in the same cycle → next cycle DataOutA=0xA5, DataOutB=0x11. A later read of 0x10 on B → 0xA5.
3. Out of range, DATA_LEN=200: write 0x3C to 210 → AddrErr=1 next cycle, memory unchanged. Read 210 on A → DataOutA=0x00, ValidA=1, AddrErr=1. An in-range read afterwards → AddrErr=0.
4. Hold behaviour: after DataOutB=0x22, drop ReadEnB for 5 cycles while RdAddrB changes → DataOutB stays 0x22 and ValidB=0 throughout.
5. Reset mid-INIT: assert nReset after 100 preload edges → all outputs 0 immediately. After release, Ready stays 0 for a full 256 edges. A write issued during INIT (0xFF to 0x20) is ignored, so a read of 0x20 after Ready → 0x20.
6. INIT_MODE=0, DATA_WIDTH=16, DATA_LEN=16, ADDR_WIDTH=4: preload takes 16 edges, every address reads 0x0000. A write of 0xBEEF to 15 reads back 0xBEEF, and AddrErr never asserts.
